// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the EEPROM master/target pair: FSM states,
// EEPROM control nibble and acknowledge levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEVADDR,
        ACK_DEV,
        WADDR,
        ACK_WADDR,
        WDATA,
        ACK_WDATA,
        RDATA,
        MACK,
        WAIT_STOP
    } i2c_state_t;

    localparam logic [3:0] EEPROM_CTRL = 4'b1010;
    localparam logic       I2C_ACK     = 1'b0;
    localparam logic       I2C_NACK    = 1'b1;

endpackage

// File: rtl/i2c_in_filter.sv
// Pad input conditioner: 2-FF synchronizer, FILT_LEN-sample majority filter
// and single-cycle edge strobes on the filtered level.
module i2c_in_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic filt,
    output logic rise,
    output logic fall
);

    logic [1:0]          sync;
    logic [FILT_LEN-1:0] win;
    logic                filt_d;
    logic                maj;

    always_comb begin
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < FILT_LEN; i++) begin
            ones += 32'(win[i]);
        end
        maj = (ones * 2) > FILT_LEN;
    end

    // Reset to the idle bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '1;
            win    <= '1;
            filt   <= 1'b1;
            filt_d <= 1'b1;
        end else begin
            sync <= {sync[0], pin};
            for (int unsigned i = FILT_LEN - 1; i > 0; i--) begin
                win[i] <= win[i-1];
            end
            win[0] <= sync[1];
            filt   <= maj;
            filt_d <= filt;
        end
    end

    assign rise = filt & ~filt_d;
    assign fall = ~filt & filt_d;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C target emulating a 256x8 24AA02-class EEPROM: oversampled SCL/SDA,
// open-drain SDA via sda_oe, page writes, sequential and random reads.
module i2c_eeprom_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = {EEPROM_CTRL, 3'b000},
    parameter int unsigned AW        = 8,
    parameter int unsigned PAGE_BITS = 3,
    parameter int unsigned FILT_LEN  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    input  logic          a2,
    input  logic          a1,
    input  logic          a0,
    input  logic          wp,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk  (clk),
        .rst  (rst),
        .pin  (scl_in),
        .filt (scl_f),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk  (clk),
        .rst  (rst),
        .pin  (sda_in),
        .filt (sda_f),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;

    i2c_state_t    state, state_next;
    logic [2:0]    bit_cnt;
    logic [6:0]    rx_sh;
    logic [7:0]    rx_byte;
    logic [7:0]    tx_sh;
    logic [AW-1:0] ptr, ptr_page, ptr_inc, rd_addr;
    logic [1:0]    fall_d;
    logic [6:0]    dev_id;
    logic          oe_want;
    logic          cnt_en, rx_en, mem_we, ptr_ld, ptr_pg_en, ptr_inc_en, tx_ld, tx_shift;

    logic [7:0] mem [2**AW];

    always_comb begin
        dev_id      = DEV_ADDR;
        dev_id[2:0] = {a2, a1, a0};
    end

    always_comb begin
        ptr_inc  = ptr + AW'(1);
        ptr_page = ptr;
        ptr_page[PAGE_BITS-1:0] = ptr[PAGE_BITS-1:0] + PAGE_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_en     = 1'b0;
        rx_en      = 1'b0;
        mem_we     = 1'b0;
        ptr_ld     = 1'b0;
        ptr_pg_en  = 1'b0;
        ptr_inc_en = 1'b0;
        tx_ld      = 1'b0;
        tx_shift   = 1'b0;
        rd_addr    = ptr;
        rx_byte    = {rx_sh, sda_f};
        oe_want    = 1'b0;

        unique case (state)
            ACK_DEV, ACK_WADDR, ACK_WDATA: oe_want = 1'b1;
            RDATA:                         oe_want = ~tx_sh[7];
            default:                       oe_want = 1'b0;
        endcase

        if (stop_det) begin
            state_next = IDLE;
        end else if (start_det) begin
            state_next = DEVADDR;
        end else if (scl_rise) begin
            unique case (state)
                DEVADDR: begin
                    cnt_en = 1'b1;
                    rx_en  = 1'b1;
                    if (bit_cnt == 3'd7)
                        state_next = (rx_byte[7:1] == dev_id) ? ACK_DEV : WAIT_STOP;
                end
                // rx_sh[0] still holds the R/W bit of the device byte here.
                ACK_DEV: begin
                    if (rx_sh[0]) begin
                        state_next = RDATA;
                        tx_ld      = 1'b1;
                    end else begin
                        state_next = WADDR;
                    end
                end
                WADDR: begin
                    cnt_en = 1'b1;
                    rx_en  = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        ptr_ld     = 1'b1;
                        state_next = ACK_WADDR;
                    end
                end
                ACK_WADDR: state_next = WDATA;
                WDATA: begin
                    cnt_en = 1'b1;
                    rx_en  = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        mem_we     = ~wp & ~rst;
                        ptr_pg_en  = 1'b1;
                        state_next = ACK_WDATA;
                    end
                end
                ACK_WDATA: state_next = WDATA;
                RDATA: begin
                    cnt_en   = 1'b1;
                    tx_shift = 1'b1;
                    if (bit_cnt == 3'd7) state_next = MACK;
                end
                MACK: begin
                    ptr_inc_en = 1'b1;
                    if (sda_f == I2C_ACK) begin
                        rd_addr    = ptr_inc;
                        tx_ld      = 1'b1;
                        state_next = RDATA;
                    end else begin
                        state_next = WAIT_STOP;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // SDA is only ever changed two cycles after SCL falls, well inside the low phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            sda_oe  <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            ptr     <= '0;
            bit_cnt <= '0;
            rx_sh   <= '0;
            tx_sh   <= '0;
            fall_d  <= '0;
        end else begin
            wr_stb <= mem_we;
            if (mem_we) begin
                wr_addr <= ptr;
                wr_data <= rx_byte;
            end
            fall_d <= {fall_d[0], scl_fall};
            if (start_det || stop_det) sda_oe <= 1'b0;
            else if (fall_d[1])        sda_oe <= oe_want;
            if (start_det)   bit_cnt <= '0;
            else if (cnt_en) bit_cnt <= bit_cnt + 3'd1;
            if (rx_en) rx_sh <= rx_byte[6:0];
            if (ptr_ld)          ptr <= AW'(rx_byte);
            else if (ptr_pg_en)  ptr <= ptr_page;
            else if (ptr_inc_en) ptr <= ptr_inc;
            if (tx_ld)         tx_sh <= mem[rd_addr];
            else if (tx_shift) tx_sh <= {tx_sh[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr] <= rx_byte;
    end

    assign busy = (state == ACK_DEV) || (state == WADDR) || (state == ACK_WADDR) ||
                  (state == WDATA) || (state == ACK_WDATA) || (state == RDATA) ||
                  (state == MACK);

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: a bit-banged I2C master drives directed
// transactions; expected ACKs, read bytes and memory commits go to queues.
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;

    localparam int Q = 12;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       glitch = 1'b0;
    logic       sda_bus;
    logic       sda_oe;
    logic       a2 = 1'b0, a1 = 1'b0, a0 = 1'b0;
    logic       wp = 1'b0;
    logic       wr_stb;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;
    string phase = "reset";

    wr_t  exp_wr_q[$];
    logic [7:0] exp_rd_q[$];
    logic exp_ack_q[$];
    logic       obs_ack;
    logic [7:0] obs_rd;
    event ev_ack, ev_rd;
    logic mon_oe = 1'b0;
    logic oe_seen = 1'b0;

    assign sda_bus = m_sda & ~sda_oe & ~glitch;

    i2c_eeprom_slave #(.AW(8), .PAGE_BITS(3), .FILT_LEN(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_in  (m_scl),
        .sda_in  (sda_bus),
        .sda_oe  (sda_oe),
        .a2      (a2),
        .a1      (a1),
        .a0      (a0),
        .wp      (wp),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", phase, name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s/%s: unexpected event", phase, name);
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (!rst && wr_stb) begin
            if (exp_wr_q.size() == 0) begin
                fail_now("wr_stb");
            end else begin
                wr_t e;
                e = exp_wr_q.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
            end
        end
    end

    initial forever begin
        @(ev_ack);
        if (exp_ack_q.size() == 0) fail_now("ack");
        else check("ack", obs_ack, exp_ack_q.pop_front());
    end

    initial forever begin
        @(ev_rd);
        if (exp_rd_q.size() == 0) fail_now("rd");
        else check("rd_data", obs_rd, exp_rd_q.pop_front());
    end

    always @(posedge clk) if (mon_oe && sda_oe) oe_seen = 1'b1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bit-level master
    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic s);
        m_sda = b; wq();
        m_scl = 1'b1; wq();
        s = sda_bus; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b0; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b1; wq();
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic exp_a);
        logic s;
        exp_ack_q.push_back(exp_a);
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        obs_ack = s;
        -> ev_ack;
    endtask

    task automatic rd_byte(input logic ack, input logic [7:0] exp);
        logic s;
        logic [7:0] v;
        v = '0;
        exp_rd_q.push_back(exp);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, s);
            v = {v[6:0], s};
        end
        send_bit(ack ? 1'b0 : 1'b1, s);
        obs_rd = v;
        -> ev_rd;
    endtask

    task automatic exp_write(input logic [7:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr_q.push_back(e);
    endtask

    task automatic random_read1(input logic [7:0] a, input logic [7:0] exp);
        i2c_start(); wr_byte(8'hA0, 1'b0); wr_byte(a, 1'b0);
        i2c_start(); wr_byte(8'hA1, 1'b0); rd_byte(1'b0, exp);
        i2c_stop();
    endtask

    initial begin
        logic s;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("sda_oe", sda_oe, 0);
        check("busy", busy, 0);
        check("wr_stb", wr_stb, 0);
        check("wr_addr", wr_addr, 0);
        check("wr_data", wr_data, 0);

        phase = "prewrite06";
        exp_write(8'h06, 8'h77);
        i2c_start(); wr_byte(8'hA0, 1'b0); wr_byte(8'h06, 1'b0); wr_byte(8'h77, 1'b0); i2c_stop();

        phase = "byte_write";
        exp_write(8'h05, 8'h3C);
        i2c_start(); wr_byte(8'hA0, 1'b0); wr_byte(8'h05, 1'b0); wr_byte(8'h3C, 1'b0);
        check("busy_mid", busy, 1);
        i2c_stop(); wq();
        check("busy_after_stop", busy, 0);

        phase = "random_read";
        random_read1(8'h05, 8'h3C);

        phase = "current_read";
        i2c_start(); wr_byte(8'hA1, 1'b0); rd_byte(1'b0, 8'h77); i2c_stop();

        phase = "page_write";
        exp_write(8'h06, 8'h11); exp_write(8'h07, 8'h22);
        exp_write(8'h00, 8'h33); exp_write(8'h01, 8'h44);
        i2c_start(); wr_byte(8'hA0, 1'b0); wr_byte(8'h06, 1'b0);
        wr_byte(8'h11, 1'b0); wr_byte(8'h22, 1'b0); wr_byte(8'h33, 1'b0); wr_byte(8'h44, 1'b0);
        i2c_stop();

        phase = "seq_read_wrap";
        exp_write(8'hFF, 8'hEE);
        i2c_start(); wr_byte(8'hA0, 1'b0); wr_byte(8'hFF, 1'b0); wr_byte(8'hEE, 1'b0); i2c_stop();
        i2c_start(); wr_byte(8'hA0, 1'b0); wr_byte(8'hFF, 1'b0);
        i2c_start(); wr_byte(8'hA1, 1'b0); rd_byte(1'b1, 8'hEE); rd_byte(1'b0, 8'h33);
        i2c_stop();

        phase = "addr_mismatch";
        oe_seen = 1'b0; mon_oe = 1'b1;
        i2c_start(); wr_byte(8'hA2, 1'b1); wr_byte(8'h00, 1'b1); wr_byte(8'h99, 1'b1);
        check("busy", busy, 0);
        i2c_stop();
        mon_oe = 1'b0;
        check("oe_seen", oe_seen, 0);

        phase = "strap_a0";
        a0 = 1'b1;
        exp_write(8'h10, 8'h5A);
        i2c_start(); wr_byte(8'hA2, 1'b0); wr_byte(8'h10, 1'b0); wr_byte(8'h5A, 1'b0); i2c_stop();
        a0 = 1'b0;

        phase = "write_protect";
        wp = 1'b1;
        i2c_start(); wr_byte(8'hA0, 1'b0); wr_byte(8'h10, 1'b0); wr_byte(8'h55, 1'b0); i2c_stop();
        wp = 1'b0;
        random_read1(8'h10, 8'h5A);

        phase = "glitch";
        wq();
        @(negedge clk) glitch = 1'b1;
        @(negedge clk) glitch = 1'b0;
        wq();
        check("busy", busy, 0);
        m_scl = 1'b0; wq();
        wr_byte(8'hA0, 1'b1);
        i2c_stop();

        phase = "partial_byte";
        exp_write(8'h30, 8'h00);
        i2c_start(); wr_byte(8'hA0, 1'b0); wr_byte(8'h30, 1'b0); wr_byte(8'h00, 1'b0); i2c_stop();
        i2c_start(); wr_byte(8'hA0, 1'b0); wr_byte(8'h20, 1'b0);
        send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b0, s);
        i2c_stop(); wq();
        check("busy", busy, 0);

        phase = "reset_mid_read";
        i2c_start(); wr_byte(8'hA0, 1'b0); wr_byte(8'h30, 1'b0);
        i2c_start(); wr_byte(8'hA1, 1'b0);
        m_sda = 1'b1; wq();
        m_scl = 1'b1; wq();
        check("sda_oe_driving", sda_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        check("sda_oe_released", sda_oe, 0);
        check("busy", busy, 0);
        rst = 1'b0;
        m_scl = 1'b0; wq();
        i2c_stop();

        phase = "after_reset";
        exp_write(8'h40, 8'hAB);
        i2c_start(); wr_byte(8'hA0, 1'b0); wr_byte(8'h40, 1'b0); wr_byte(8'hAB, 1'b0); i2c_stop();
        random_read1(8'h40, 8'hAB);

        phase = "final";
        repeat (20) @(negedge clk);
        check("wr_q_left", exp_wr_q.size(), 0);
        check("rd_q_left", exp_rd_q.size(), 0);
        check("ack_q_left", exp_ack_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
